icache_refill_server: RTL and testbench
=======================================

ICACHE_REFILL_SERVER -- requirements
Module: icache_refill_server

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk  in  1  rising-edge clock; rstn  in  1  async active-low reset.
REQ-002 SHALL have port i_miss_drive  in  1  single-cycle pulse requesting a refill (Icache miss).
REQ-003 SHALL have port i_miss_addr_34  in  34  miss physical address, sampled when i_miss_drive=1.
REQ-004 SHALL have port o_miss_free  out  1  single-cycle pulse acknowledging that the request was accepted.
REQ-005 SHALL have port o_refill_drive  out  1  single-cycle pulse marking o_refill_line_256 valid.
REQ-006 SHALL have port o_refill_line_256  out  256  refill line; beat k occupies bits [64k+63:64k].
REQ-007 SHALL have port i_refill_free  in  1  single-cycle pulse; the Icache has consumed the line.
REQ-008 SHALL have port o_mem_req  out  1  level; memory read request, held until acked.
REQ-009 SHALL have port o_mem_addr_34  out  34  line base address, with [4:0] forced to 0.
REQ-010 SHALL have port i_mem_ack  in  1  memory accepted the request.
REQ-011 SHALL have port i_mem_rvalid  in  1  one 64-bit beat valid.
REQ-012 SHALL have port i_mem_rdata_64  in  64  beat data.
REQ-013 SHALL have port o_busy  out  1  state is not IDLE.
REQ-014 SHALL have port o_overflow  out  1  sticky flag; a request was dropped.

Function
REQ-015 SHALL implement states IDLE, LOOKUP, MEMREQ, BEAT, RESP, WAITFREE.
REQ-016 IDLE: on i_miss_drive, SHALL latch the address, pulse o_miss_free in the next cycle, and go to LOOKUP.
REQ-017 SHALL keep a one-entry last-line buffer consisting of a tag (addr[33:5]), the 256-bit line and a valid bit.
REQ-018 LOOKUP: if the buffer is valid and its tag equals latched addr[33:5], SHALL go to RESP without any memory access; otherwise SHALL go to MEMREQ.
REQ-019 MEMREQ: SHALL hold o_mem_req=1 with o_mem_addr_34 stable until i_mem_ack=1, then go to BEAT with the beat counter at 0.
REQ-020 BEAT: each i_mem_rvalid cycle SHALL write i_mem_rdata_64 into the slot selected by the 2-bit counter and then increment the counter.
REQ-021 BEAT: on the rvalid for beat 3, SHALL update the buffer (tag, line, valid=1) and go to RESP; the counter wraps to 0.
REQ-022 SHALL ignore i_mem_rvalid outside the BEAT state.
REQ-023 RESP: SHALL pulse o_refill_drive for exactly one cycle and then go to WAITFREE.
REQ-024 o_refill_line_256 SHALL be driven from the buffer and stay stable from RESP until i_refill_free is received.
REQ-025 WAITFREE: on i_refill_free, SHALL go to IDLE, or go to LOOKUP if a request is pending.
REQ-026 SHALL ignore i_refill_free in any state other than WAITFREE.
REQ-027 i_miss_drive while not IDLE: if the 1-deep pending slot is empty, SHALL store the address there without pulsing o_miss_free yet.
REQ-028 A pending request's o_miss_free SHALL pulse in the cycle the server leaves WAITFREE for it.
REQ-029 i_miss_drive while the pending slot is full SHALL be dropped and SHALL set o_overflow=1.
REQ-030 o_overflow SHALL stay set until reset.
REQ-031 If i_miss_drive and i_refill_free arrive in the same cycle in WAITFREE, SHALL treat the new request as pending and serve it next.
REQ-032 SHALL have a latency of 3 cycles from i_miss_drive to o_refill_drive on a buffer hit.
REQ-033 On a miss, latency SHALL be 2 + ack wait + 4 beats + 1 cycles.

Reset
REQ-034 rstn=0 SHALL force, asynchronously: state IDLE, all pulse outputs 0, o_mem_req=0, o_busy=0, o_overflow=0.
REQ-035 rstn=0 SHALL also clear the buffer valid bit and the pending slot, and zero o_refill_line_256 and o_mem_addr_34.
REQ-036 Reset asserted mid-transfer SHALL abandon the transfer.
REQ-037 Any beats arriving after reset is released SHALL be ignored.

Verification
REQ-038 Cold miss: addr 0x0_0000_1234 with beats 0x11..,0x22..,0x33..,0x44.. -> o_mem_addr_34=0x0_0000_1220, o_refill_drive pulses once, and line = {0x44..,0x33..,0x22..,0x11..}.
REQ-039 Repeat of the same line (addr 0x..123C) after i_refill_free -> no o_mem_req, and o_refill_drive follows 3 cycles after the drive.
REQ-040 Drive during BEAT, then a second drive -> the first is served after WAITFREE, the second is dropped, and o_overflow=1.
REQ-041 i_mem_ack delayed 5 cycles -> o_mem_req and o_mem_addr_34 are held stable for all 5 cycles.
REQ-042 Reset asserted after beat 1 -> outputs return to reset values, and stale rvalid beats after reset produce no o_refill_drive.
REQ-043 Simultaneous i_refill_free and i_miss_drive -> the new request is served, and o_miss_free pulses on leaving WAITFREE.

Source files
------------

// File: rtl/icache_refill_server.sv
// Purpose: serves instruction-cache line refills. It keeps the most recently
//   fetched 32-byte line for fast repeat hits and reads misses from memory as
//   four 64-bit beats.
// Latency: a hit gives o_refill_drive 3 cycles after i_miss_drive. A miss takes
//   2 + (cycles holding o_mem_req) + 4 beats + 1.
// Backpressure: a single pending slot absorbs one request that arrives while the
//   server is busy. Any request beyond that is dropped and sets the sticky
//   o_overflow flag.
// Ports:
//   clk, rstn                          clock, asynchronous active-low reset
//   i_miss_drive, i_miss_addr_34       refill request pulse and miss address
//   o_miss_free                        request-accepted pulse
//   o_refill_drive, o_refill_line_256  line-valid pulse and line data
//                                      (beat k is in bits [64k+63:64k])
//   i_refill_free                      the cache has consumed the line
//   o_mem_req, o_mem_addr_34, i_mem_ack             memory read request handshake
//   i_mem_rvalid, i_mem_rdata_64                    read beats from memory
//   o_busy, o_overflow                              status outputs
module icache_refill_server (
  input  logic         clk,
  input  logic         rstn,
  input  logic         i_miss_drive,
  input  logic [33:0]  i_miss_addr_34,
  output logic         o_miss_free,
  output logic         o_refill_drive,
  output logic [255:0] o_refill_line_256,
  input  logic         i_refill_free,
  output logic         o_mem_req,
  output logic [33:0]  o_mem_addr_34,
  input  logic         i_mem_ack,
  input  logic         i_mem_rvalid,
  input  logic [63:0]  i_mem_rdata_64,
  output logic         o_busy,
  output logic         o_overflow
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOOKUP   = 3'd1,
    MEMREQ   = 3'd2,
    BEAT     = 3'd3,
    RESP     = 3'd4,
    WAITFREE = 3'd5
  } state_t;

  state_t       state;
  logic [33:0]  req_addr;   // address of the request being served
  logic [33:0]  pend_addr;  // address of the one queued request
  logic         pend_vld;
  logic [28:0]  buf_tag;    // last-line buffer: tag = addr[33:5]
  logic [255:0] buf_line;
  logic         buf_vld;
  logic [1:0]   beat_cnt;
  logic         buf_hit;

  assign buf_hit           = buf_vld && (buf_tag == req_addr[33:5]);
  assign o_busy            = (state != IDLE);
  // The line is always presented straight from the buffer. The buffer is only
  // written in BEAT, so the data stays stable from RESP until i_refill_free.
  assign o_refill_line_256 = buf_line;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= IDLE;
      req_addr       <= '0;
      pend_addr      <= '0;
      pend_vld       <= 1'b0;
      buf_tag        <= '0;
      buf_line       <= '0;
      buf_vld        <= 1'b0;
      beat_cnt       <= 2'd0;
      o_miss_free    <= 1'b0;
      o_refill_drive <= 1'b0;
      o_mem_req      <= 1'b0;
      o_mem_addr_34  <= '0;
      o_overflow     <= 1'b0;
    end else begin
      o_miss_free    <= 1'b0;
      o_refill_drive <= 1'b0;

      // Requests that arrive while busy are queued in the pending slot.
      // If the slot is already occupied, the request is lost. The WAITFREE
      // branch below overrides this capture when it serves a request directly.
      if (i_miss_drive && (state != IDLE)) begin
        if (!pend_vld) begin
          pend_vld  <= 1'b1;
          pend_addr <= i_miss_addr_34;
        end else begin
          o_overflow <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (i_miss_drive) begin
            req_addr    <= i_miss_addr_34;
            o_miss_free <= 1'b1;
            state       <= LOOKUP;
          end
        end

        LOOKUP: begin
          if (buf_hit) begin
            state <= RESP;
          end else begin
            o_mem_req     <= 1'b1;
            o_mem_addr_34 <= {req_addr[33:5], 5'd0};
            state         <= MEMREQ;
          end
        end

        MEMREQ: begin
          if (i_mem_ack) begin
            o_mem_req <= 1'b0;
            beat_cnt  <= 2'd0;
            // The beats overwrite the buffer in place, so its old contents stop
            // being a valid hit target from this point on.
            buf_vld   <= 1'b0;
            state     <= BEAT;
          end
        end

        BEAT: begin
          if (i_mem_rvalid) begin
            buf_line[{beat_cnt, 6'd0} +: 64] <= i_mem_rdata_64;
            beat_cnt <= beat_cnt + 2'd1;
            if (beat_cnt == 2'd3) begin
              buf_tag <= req_addr[33:5];
              buf_vld <= 1'b1;
              state   <= RESP;
            end
          end
        end

        RESP: begin
          o_refill_drive <= 1'b1;
          state          <= WAITFREE;
        end

        WAITFREE: begin
          if (i_refill_free) begin
            if (pend_vld) begin
              req_addr    <= pend_addr;
              pend_vld    <= 1'b0;
              o_miss_free <= 1'b1;
              state       <= LOOKUP;
            end else if (i_miss_drive) begin
              // A request that arrives together with the free is served next.
              // It does not stay in the pending slot.
              req_addr    <= i_miss_addr_34;
              pend_vld    <= 1'b0;
              o_miss_free <= 1'b1;
              state       <= LOOKUP;
            end else begin
              state <= IDLE;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_refill_server.sv
module tb_icache_refill_server;

  logic         clk;
  logic         rstn;
  logic         i_miss_drive;
  logic [33:0]  i_miss_addr_34;
  logic         o_miss_free;
  logic         o_refill_drive;
  logic [255:0] o_refill_line_256;
  logic         i_refill_free;
  logic         o_mem_req;
  logic [33:0]  o_mem_addr_34;
  logic         i_mem_ack;
  logic         i_mem_rvalid;
  logic [63:0]  i_mem_rdata_64;
  logic         o_busy;
  logic         o_overflow;

  icache_refill_server dut (
    .clk               (clk),
    .rstn              (rstn),
    .i_miss_drive      (i_miss_drive),
    .i_miss_addr_34    (i_miss_addr_34),
    .o_miss_free       (o_miss_free),
    .o_refill_drive    (o_refill_drive),
    .o_refill_line_256 (o_refill_line_256),
    .i_refill_free     (i_refill_free),
    .o_mem_req         (o_mem_req),
    .o_mem_addr_34     (o_mem_addr_34),
    .i_mem_ack         (i_mem_ack),
    .i_mem_rvalid      (i_mem_rvalid),
    .i_mem_rdata_64    (i_mem_rdata_64),
    .o_busy            (o_busy),
    .o_overflow        (o_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Memory responder. It acks on the ack_delay-th cycle of o_mem_req and then
  // returns the four beats of mem_line, one per cycle, lowest beat first.
  logic [255:0] mem_line;
  int           ack_delay;
  bit           mem_en;
  int           beat_idx;
  int           req_n;

  initial begin
    i_mem_ack      = 1'b0;
    i_mem_rvalid   = 1'b0;
    i_mem_rdata_64 = '0;
    forever begin
      @(negedge clk);
      if (mem_en) begin
        i_mem_ack    = 1'b0;
        i_mem_rvalid = 1'b0;
        if (beat_idx >= 0 && beat_idx < 4) begin
          i_mem_rvalid   = 1'b1;
          i_mem_rdata_64 = mem_line[beat_idx*64 +: 64];
          beat_idx++;
        end
        if (o_mem_req) begin
          req_n++;
          if (req_n == ack_delay) begin
            i_mem_ack = 1'b1;
            beat_idx  = 0;
            req_n     = 0;
          end
        end
      end
    end
  end

  // Observes one request that was issued at the previous negedge, checks it,
  // and then frees the line.
  task automatic watch(input string nm, input int exp_lat, input int exp_reqc,
                       input logic [33:0] exp_maddr, input logic [255:0] exp_line);
    int          lat;
    int          reqc;
    logic [33:0] first_addr;
    logic        addr_stable;
    lat = -1; reqc = 0; first_addr = '0; addr_stable = 1'b1;
    for (int t = 1; t <= 40 && lat < 0; t++) begin
      @(negedge clk);
      if (t == 1) begin
        i_miss_drive = 1'b0;
        chk({nm, " miss_free"}, 256'(o_miss_free), 256'(1));
      end
      if (o_mem_req) begin
        if (reqc == 0) first_addr = o_mem_addr_34;
        else if (o_mem_addr_34 !== first_addr) addr_stable = 1'b0;
        reqc++;
      end
      if (o_refill_drive) lat = t;
    end
    chk({nm, " latency"}, 256'(lat), 256'(exp_lat));
    chk({nm, " mem_req cycles"}, 256'(reqc), 256'(exp_reqc));
    if (exp_reqc > 0) begin
      chk({nm, " mem_addr"}, 256'(first_addr), 256'(exp_maddr));
      chk({nm, " mem_addr stable"}, 256'(addr_stable), 256'(1));
    end
    chk({nm, " line"}, o_refill_line_256, exp_line);
    @(negedge clk);
    chk({nm, " refill pulse width"}, 256'(o_refill_drive), 256'(0));
    chk({nm, " busy in waitfree"}, 256'(o_busy), 256'(1));
    chk({nm, " line stable"}, o_refill_line_256, exp_line);
    i_refill_free = 1'b1;
    @(negedge clk);
    i_refill_free = 1'b0;
    chk({nm, " idle after free"}, 256'(o_busy), 256'(0));
  endtask

  typedef struct {
    string        nm;
    logic [33:0]  addr;
    logic [63:0]  b0, b1, b2, b3;
    int           ack_d;
    int           exp_lat;
    int           exp_reqc;
    logic [33:0]  exp_maddr;
    logic [255:0] exp_line;
  } vec_t;

  vec_t vecs[5];

  localparam logic [63:0] B11 = 64'h1111_1111_1111_1111, B22 = 64'h2222_2222_2222_2222;
  localparam logic [63:0] B33 = 64'h3333_3333_3333_3333, B44 = 64'h4444_4444_4444_4444;
  localparam logic [63:0] BA0 = 64'hA0A0_A0A0_A0A0_A0A0, BA1 = 64'hA1A1_A1A1_A1A1_A1A1;
  localparam logic [63:0] BA2 = 64'hA2A2_A2A2_A2A2_A2A2, BA3 = 64'hA3A3_A3A3_A3A3_A3A3;
  localparam logic [63:0] B55 = 64'h5555_5555_5555_5555, B66 = 64'h6666_6666_6666_6666;
  localparam logic [63:0] B77 = 64'h7777_7777_7777_7777, B88 = 64'h8888_8888_8888_8888;
  localparam logic [63:0] B99 = 64'h9999_9999_9999_9999, BBB = 64'hBBBB_BBBB_BBBB_BBBB;
  localparam logic [63:0] BCC = 64'hCCCC_CCCC_CCCC_CCCC, BDD = 64'hDDDD_DDDD_DDDD_DDDD;

  logic [255:0] line_a, line_x, line_p;
  bit           seen;

  initial begin
    rstn = 1'b0; i_miss_drive = 1'b0; i_miss_addr_34 = '0; i_refill_free = 1'b0;
    mem_line = '0; ack_delay = 1; mem_en = 1'b1; beat_idx = -1; req_n = 0;

    line_a = {B44, B33, B22, B11};
    line_x = {BDD, BCC, BBB, B99};
    line_p = {BA3, BA2, BA1, BA0};
    vecs[0] = '{"cold miss",    34'h0_0000_1234, B11, B22, B33, B44, 1, 8, 1, 34'h0_0000_1220, line_a};
    vecs[1] = '{"repeat hit",   34'h0_0000_123C, 0, 0, 0, 0, 1, 3, 0, 34'h0, line_a};
    vecs[2] = '{"ack delay 5",  34'h2_0000_0047, BA0, BA1, BA2, BA3, 5, 12, 5, 34'h2_0000_0040, line_p};
    vecs[3] = '{"hit 2",        34'h2_0000_005F, 0, 0, 0, 0, 1, 3, 0, 34'h0, line_p};
    vecs[4] = '{"evicted miss", 34'h0_0000_1234, B55, B66, B77, B88, 2, 9, 2, 34'h0_0000_1220,
                {B88, B77, B66, B55}};

    // Reset state
    #12;
    chk("reset busy", 256'(o_busy), 256'(0));
    chk("reset mem_req", 256'(o_mem_req), 256'(0));
    chk("reset overflow", 256'(o_overflow), 256'(0));
    chk("reset line", o_refill_line_256, 256'(0));
    chk("reset mem_addr", 256'(o_mem_addr_34), 256'(0));
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // Table-driven transactions
    for (int i = 0; i < 5; i++) begin
      mem_line  = {vecs[i].b3, vecs[i].b2, vecs[i].b1, vecs[i].b0};
      ack_delay = vecs[i].ack_d;
      @(negedge clk);
      i_miss_addr_34 = vecs[i].addr;
      i_miss_drive   = 1'b1;
      watch(vecs[i].nm, vecs[i].exp_lat, vecs[i].exp_reqc, vecs[i].exp_maddr, vecs[i].exp_line);
    end

    // Queued request plus a dropped request during BEAT
    mem_line = {BDD, BCC, BBB, B99}; ack_delay = 1;
    @(negedge clk);
    i_miss_addr_34 = 34'h3_0000_0000; i_miss_drive = 1'b1;
    seen = 1'b0;
    for (int t = 1; t <= 14; t++) begin
      @(negedge clk);
      if (t >= 10 && o_mem_req) seen = 1'b1;
      case (t)
        1:  begin i_miss_drive = 1'b0; chk("ovf first miss_free", 256'(o_miss_free), 256'(1)); end
        3:  begin i_miss_drive = 1'b1; i_miss_addr_34 = 34'h3_0000_0008; end
        4:  begin
              i_miss_addr_34 = 34'h1_2345_6780;
              chk("ovf queued no miss_free", 256'(o_miss_free), 256'(0));
            end
        5:  begin
              i_miss_drive = 1'b0;
              chk("ovf flag set", 256'(o_overflow), 256'(1));
              chk("ovf dropped no miss_free", 256'(o_miss_free), 256'(0));
            end
        8:  begin
              chk("ovf first refill", 256'(o_refill_drive), 256'(1));
              chk("ovf first line", o_refill_line_256, line_x);
            end
        9:  i_refill_free = 1'b1;
        10: begin
              i_refill_free = 1'b0;
              chk("ovf pending miss_free", 256'(o_miss_free), 256'(1));
              chk("ovf pending busy", 256'(o_busy), 256'(1));
            end
        12: chk("ovf pending refill", 256'(o_refill_drive), 256'(1));
        13: i_refill_free = 1'b1;
        14: begin
              i_refill_free = 1'b0;
              chk("ovf idle after pending", 256'(o_busy), 256'(0));
            end
        default: ;
      endcase
    end
    chk("ovf pending hit no mem_req", 256'(seen), 256'(0));
    seen = 1'b0;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      if (o_refill_drive || o_busy) seen = 1'b1;
    end
    chk("ovf dropped not served", 256'(seen), 256'(0));
    chk("ovf sticky", 256'(o_overflow), 256'(1));

    // Simultaneous free and new request in WAITFREE
    @(negedge clk);
    i_miss_addr_34 = 34'h3_0000_0010; i_miss_drive = 1'b1;
    seen = 1'b0;
    for (int t = 1; t <= 9; t++) begin
      @(negedge clk);
      if (o_mem_req) seen = 1'b1;
      case (t)
        1: i_miss_drive = 1'b0;
        3: chk("sim first refill", 256'(o_refill_drive), 256'(1));
        4: begin
             i_refill_free = 1'b1; i_miss_drive = 1'b1; i_miss_addr_34 = 34'h3_0000_0018;
             chk("sim no early miss_free", 256'(o_miss_free), 256'(0));
           end
        5: begin
             i_refill_free = 1'b0; i_miss_drive = 1'b0;
             chk("sim miss_free on leave", 256'(o_miss_free), 256'(1));
             chk("sim busy", 256'(o_busy), 256'(1));
           end
        7: begin
             chk("sim second refill", 256'(o_refill_drive), 256'(1));
             chk("sim second line", o_refill_line_256, line_x);
           end
        8: i_refill_free = 1'b1;
        9: begin i_refill_free = 1'b0; chk("sim idle", 256'(o_busy), 256'(0)); end
        default: ;
      endcase
    end
    chk("sim no mem_req", 256'(seen), 256'(0));

    // Reset asserted after beat 1 of a miss
    mem_line = {64'hF3F3_F3F3_F3F3_F3F3, 64'hF2F2_F2F2_F2F2_F2F2,
                64'hF1F1_F1F1_F1F1_F1F1, 64'hF0F0_F0F0_F0F0_F0F0};
    ack_delay = 1;
    @(negedge clk);
    i_miss_addr_34 = 34'h1_0000_0100; i_miss_drive = 1'b1;
    for (int t = 1; t <= 4; t++) begin
      @(negedge clk);
      if (t == 1) i_miss_drive = 1'b0;
    end
    @(posedge clk);
    #2;
    mem_en = 1'b0; i_mem_rvalid = 1'b0; i_mem_ack = 1'b0;
    rstn = 1'b0;
    #1;
    chk("rst busy", 256'(o_busy), 256'(0));
    chk("rst mem_req", 256'(o_mem_req), 256'(0));
    chk("rst overflow", 256'(o_overflow), 256'(0));
    chk("rst line", o_refill_line_256, 256'(0));
    chk("rst mem_addr", 256'(o_mem_addr_34), 256'(0));
    chk("rst refill_drive", 256'(o_refill_drive), 256'(0));
    @(negedge clk);
    rstn = 1'b1;
    seen = 1'b0;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      if (o_refill_drive || o_busy || o_miss_free) seen = 1'b1;
      i_mem_rvalid   = (t < 3);
      i_mem_rdata_64 = 64'hDEAD_BEEF_0000_0000 | 64'(t);
    end
    i_mem_rvalid = 1'b0;
    chk("stale beats ignored", 256'(seen), 256'(0));
    beat_idx = -1; req_n = 0; mem_en = 1'b1;

    // The buffer was invalidated by reset, so a formerly cached line misses.
    mem_line = {64'h0404_0404_0404_0404, 64'h0303_0303_0303_0303,
                64'h0202_0202_0202_0202, 64'h0101_0101_0101_0101};
    ack_delay = 1;
    @(negedge clk);
    i_miss_addr_34 = 34'h3_0000_0000; i_miss_drive = 1'b1;
    watch("post-reset miss", 8, 1, 34'h3_0000_0000,
          {64'h0404_0404_0404_0404, 64'h0303_0303_0303_0303,
           64'h0202_0202_0202_0202, 64'h0101_0101_0101_0101});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
